// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared definitions for the decode->execute pipeline stage: default widths,
// the NOP control bundle and the stage occupancy state encoding.
package riscv_pipe_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_CTRL_WIDTH     = 32;
    localparam int DEF_ALU_CTRL_WIDTH = 4;
    localparam int DEF_INSTR_BYTES    = 4;

    // Control bundle presented downstream whenever no valid instruction is held.
    localparam logic [DEF_CTRL_WIDTH-1:0] NOP_CTRL = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic int payload_width(input int data_w, input int ctrl_w, input int alu_w);
        return 6 * data_w + ctrl_w + alu_w;
    endfunction

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// Decode->execute channel: upstream valid/ready payload, flush, downstream
// valid/ready payload and occupancy. The stage itself uses the slave modport.
interface id_ex_pipe_stage_if
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH,
    parameter int ALU_CTRL_WIDTH = DEF_ALU_CTRL_WIDTH
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     instr_in;
    logic [DATA_WIDTH-1:0]     pc_in;
    logic [CTRL_WIDTH-1:0]     ctrl_in;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_in;
    logic [DATA_WIDTH-1:0]     imm_in;
    logic [DATA_WIDTH-1:0]     op_a_in;
    logic [DATA_WIDTH-1:0]     op_b_in;
    logic                      flush;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     instr_out;
    logic [DATA_WIDTH-1:0]     pc_out;
    logic [DATA_WIDTH-1:0]     npc_out;
    logic [CTRL_WIDTH-1:0]     ctrl_out;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_out;
    logic [DATA_WIDTH-1:0]     imm_out;
    logic [DATA_WIDTH-1:0]     op_a_out;
    logic [DATA_WIDTH-1:0]     op_b_out;
    logic [1:0]                occupancy;

    modport slave (
        input  in_valid, instr_in, pc_in, ctrl_in, alu_ctrl_in, imm_in, op_a_in, op_b_in,
        input  flush, out_ready,
        output in_ready, out_valid, instr_out, pc_out, npc_out, ctrl_out, alu_ctrl_out,
        output imm_out, op_a_out, op_b_out, occupancy
    );

    modport master (
        output in_valid, instr_in, pc_in, ctrl_in, alu_ctrl_in, imm_in, op_a_in, op_b_in,
        output flush, out_ready,
        input  in_ready, out_valid, instr_out, pc_out, npc_out, ctrl_out, alu_ctrl_out,
        input  imm_out, op_a_out, op_b_out, occupancy
    );

endinterface

// File: rtl/id_ex_pipe_stage_slot.sv
// Width-generic payload register: loads when asked, otherwise holds.
// Cleared by the asynchronous active-low reset.
module pipe_payload_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = load ? load_data : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Decode->execute pipeline register with valid/ready handshake, flush, NOP bubbles
// and an optional skid slot that makes in_ready a registered signal.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_EMPTY | nothing held; out_valid=0, ctrl_out forced to NOP
//  ST_BUSY  | main slot holds the entry presented downstream
//  ST_FULL  | main slot presented, skid slot holds the next entry (SKID_EN=1 only)
module id_ex_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH,
    parameter int ALU_CTRL_WIDTH = DEF_ALU_CTRL_WIDTH,
    parameter int INSTR_BYTES    = DEF_INSTR_BYTES,
    parameter bit SKID_EN        = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_pipe_stage_if.slave  bus
);

    localparam int PW = payload_width(DATA_WIDTH, CTRL_WIDTH, ALU_CTRL_WIDTH);

    stage_state_e state_d;
    stage_state_e state_q;
    logic         in_ready_d;
    logic         in_ready_q;

    logic          in_ready;
    logic          out_valid;
    logic          accept;
    logic          emit;
    logic          main_load;
    logic          skid_load;
    logic          main_sel_skid;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_load_data;
    logic [PW-1:0] main_payload;
    logic [PW-1:0] skid_payload;

    logic [DATA_WIDTH-1:0]     npc_in;
    logic [DATA_WIDTH-1:0]     instr_w;
    logic [DATA_WIDTH-1:0]     pc_w;
    logic [DATA_WIDTH-1:0]     npc_w;
    logic [CTRL_WIDTH-1:0]     ctrl_w;
    logic [ALU_CTRL_WIDTH-1:0] alu_w;
    logic [DATA_WIDTH-1:0]     imm_w;
    logic [DATA_WIDTH-1:0]     op_a_w;
    logic [DATA_WIDTH-1:0]     op_b_w;

    // Carry out of the adder is dropped so the next PC wraps modulo 2^DATA_WIDTH.
    assign npc_in = bus.pc_in + DATA_WIDTH'(INSTR_BYTES);

    assign in_payload = {bus.instr_in, bus.pc_in, npc_in, bus.ctrl_in, bus.alu_ctrl_in,
                         bus.imm_in, bus.op_a_in, bus.op_b_in};

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign emit      = out_valid && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_BUSY;
                    main_load = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && !emit && SKID_EN) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d       = ST_BUSY;
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush discards held and incoming entries; an emit this cycle still happened.
        if (bus.flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign main_load_data = main_sel_skid ? skid_payload : in_payload;

    pipe_payload_slot #(.WIDTH(PW)) u_main_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .load_data (main_load_data),
        .data      (main_payload)
    );

    if (SKID_EN) begin : g_skid
        pipe_payload_slot #(.WIDTH(PW)) u_skid_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (skid_load),
            .load_data (in_payload),
            .data      (skid_payload)
        );
    end else begin : g_no_skid
        assign skid_payload = '0;
    end

    assign {instr_w, pc_w, npc_w, ctrl_w, alu_w, imm_w, op_a_w, op_b_w} = main_payload;

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.instr_out    = instr_w;
    assign bus.pc_out       = pc_w;
    assign bus.npc_out      = npc_w;
    assign bus.ctrl_out     = out_valid ? ctrl_w : CTRL_WIDTH'(NOP_CTRL);
    assign bus.alu_ctrl_out = alu_w;
    assign bus.imm_out      = imm_w;
    assign bus.op_a_out     = op_a_w;
    assign bus.op_b_out     = op_b_w;
    assign bus.occupancy    = state_q;

endmodule
